// File: rtl/fold_sched_pkg.sv
// Shared types and constants for the fold-datapath frame scheduler.
package fold_sched_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 5;
  localparam int FRM_CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;
endpackage

// File: rtl/fold_frame_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves only on the update strobe.
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);
  logic last1;  // source 1 was served most recently

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last1 ? 2'b01 : 2'b10;
  end

  // Reset value of 1 hands the first contested grant to source 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)            last1 <= 1'b1;
    else if (upd && |gnt)   last1 <= gnt[1];
  end
endmodule

// File: rtl/fold_frame_sched.sv
// Two-source frame scheduler feeding a fold datapath (nw window, len/k config).
// Optional per-source completed-frame counters: define FOLD_SCHED_FRMCNT_EN.
module fold_frame_sched
  import fold_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [DATA_W-1:0]    s0_data,
  input  logic                 s0_valid,
  input  logic                 s0_last,
  output logic                 s0_ready,
  input  logic [DATA_W-1:0]    s1_data,
  input  logic                 s1_valid,
  input  logic                 s1_last,
  output logic                 s1_ready,
  input  logic [CNT_W-1:0]     cfg0_len,
  input  logic [CNT_W-1:0]     cfg0_k,
  input  logic [CNT_W-1:0]     cfg1_len,
  input  logic [CNT_W-1:0]     cfg1_k,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 nw,
  output logic [CNT_W-1:0]     len,
  output logic [CNT_W-1:0]     k,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 len_err,
  output logic [FRM_CNT_W-1:0] frm_cnt0,
  output logic [FRM_CNT_W-1:0] frm_cnt1
);
  state_e             state, nxt;
  logic [1:0]         req, gnt, sel;
  logic               start, xfer, fire, fin, at_end;
  logic               src_valid, src_last;
  logic [DATA_W-1:0]  src_data;
  logic [CNT_W-1:0]   pos, cfg_len_w, cfg_k_w, cl_len, cl_k;

  assign req   = {s1_valid, s0_valid};
  assign start = (state == IDLE) && (|req);

  rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .upd    (start),
    .gnt    (gnt)
  );

  // Clamp the winner's config as it is captured.
  assign cfg_len_w = gnt[1] ? cfg1_len : cfg0_len;
  assign cfg_k_w   = gnt[1] ? cfg1_k   : cfg0_k;
  assign cl_len    = (cfg_len_w == '0) ? CNT_W'(1) : cfg_len_w;
  assign cl_k      = (cfg_k_w > cl_len) ? cl_len : cfg_k_w;

  assign xfer      = (state == XFER);
  assign src_valid = sel[1] ? s1_valid : s0_valid;
  assign src_last  = sel[1] ? s1_last  : s0_last;
  assign src_data  = sel[1] ? s1_data  : s0_data;

  assign m_valid  = xfer && src_valid;
  assign m_data   = xfer ? src_data : '0;
  assign s0_ready = xfer && sel[0] && m_ready;
  assign s1_ready = xfer && sel[1] && m_ready;
  assign at_end   = (pos == len);
  assign m_last   = m_valid && (at_end || src_last);
  assign fire     = m_valid && m_ready;
  assign fin      = fire && m_last;
  assign nw       = xfer && (k != '0) && (pos > len - k);
  assign busy     = (state != IDLE);
  assign grant    = busy ? sel : 2'b00;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (|req) nxt = XFER;
      XFER:    if (fin)  nxt = GAP;
      GAP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel     <= 2'b00;
      len     <= '0;
      k       <= '0;
      pos     <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= fin && (at_end != src_last);
      if (start) begin
        sel <= gnt;
        len <= cl_len;
        k   <= cl_k;
        pos <= CNT_W'(1);
      end else if (fire && (pos != '1)) begin
        pos <= pos + CNT_W'(1);
      end
    end
  end

`ifdef FOLD_SCHED_FRMCNT_EN
  logic [FRM_CNT_W-1:0] cnt0, cnt1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (fin) begin
      if (sel[0]) cnt0 <= cnt0 + FRM_CNT_W'(1);
      if (sel[1]) cnt1 <= cnt1 + FRM_CNT_W'(1);
    end
  end

  assign frm_cnt0 = cnt0;
  assign frm_cnt1 = cnt1;
`else
  assign frm_cnt0 = '0;
  assign frm_cnt1 = '0;
`endif
endmodule

// File: tb/tb_fold_frame_sched.sv
// Directed bench for fold_frame_sched with a frame-level reference model.
module tb_fold_frame_sched;
  localparam int DW = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] s0_data, s1_data, m_data;
  logic          s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
  logic [CW-1:0] cfg0_len, cfg0_k, cfg1_len, cfg1_k, len, k;
  logic          m_valid, m_last, m_ready, nw, busy, len_err;
  logic [1:0]    grant;
  logic [15:0]   frm_cnt0, frm_cnt1;

  always #5 clk = ~clk;

  fold_frame_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .cfg0_len(cfg0_len), .cfg0_k(cfg0_k), .cfg1_len(cfg1_len), .cfg1_k(cfg1_k),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .nw(nw), .len(len), .k(k), .grant(grant), .busy(busy), .len_err(len_err),
    .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1)
  );

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t q0[$], q1[$];
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    s0_valid = (q0.size() > 0);
    s0_data  = s0_valid ? q0[0].d : '0;
    s0_last  = s0_valid ? q0[0].l : 1'b0;
    s1_valid = (q1.size() > 0);
    s1_data  = s1_valid ? q1[0].d : '0;
    s1_last  = s1_valid ? q1[0].l : 1'b0;
  endtask

  task automatic push(input int src, input int n, input int base, input int last_at);
    beat_t b;
    for (int i = 1; i <= n; i++) begin
      b.d = DW'(base + i);
      b.l = (i == last_at) || (last_at < 0 && i == n);
      if (src == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // Source drivers: pop the head once the DUT has accepted it.
  logic a0, a1;
  initial forever begin
    @(negedge clk);
    a0 = s0_valid && s0_ready;
    a1 = s1_valid && s1_ready;
    @(posedge clk);
    #1;
    if (a0 && q0.size() > 0) void'(q0.pop_front());
    if (a1 && q1.size() > 0) void'(q1.pop_front());
    drive();
  end

  // Reference model: frame owner, 1-based beat number, clamped config.
  int md_ph = 0, md_own = 0, md_beat = 0, md_len = 0, md_k = 0, md_lastsrv = 1;
  int md_err = 0, mc0 = 0, mc1 = 0;

  always @(negedge clk) begin
    logic sv, sl;
    logic [DW-1:0] sd;
    int e_last, e_nw, win, cl, ck;
    if (!resetn) begin
      chk("rst_busy", busy, 0);     chk("rst_grant", grant, 0);
      chk("rst_mvalid", m_valid, 0); chk("rst_mlast", m_last, 0);
      chk("rst_mdata", m_data, 0);   chk("rst_nw", nw, 0);
      chk("rst_rdy", {s1_ready, s0_ready}, 0);
      chk("rst_len", len, 0);        chk("rst_k", k, 0);
      chk("rst_err", len_err, 0);    chk("rst_cnt", {frm_cnt1, frm_cnt0}, 0);
      md_ph = 0; md_own = 0; md_beat = 0; md_len = 0; md_k = 0;
      md_lastsrv = 1; md_err = 0; mc0 = 0; mc1 = 0;
    end else begin
      sv = (md_own == 1) ? s1_valid : s0_valid;
      sl = (md_own == 1) ? s1_last  : s0_last;
      sd = (md_own == 1) ? s1_data  : s0_data;
      if (md_ph != 1) sv = 1'b0;
      e_last = (sv && (md_beat == md_len || sl)) ? 1 : 0;
      e_nw   = (md_ph == 1 && md_k != 0 && md_beat > md_len - md_k) ? 1 : 0;
      chk("busy", busy, (md_ph != 0) ? 1 : 0);
      chk("grant", grant, (md_ph == 0) ? 0 : (1 << md_own));
      chk("m_valid", m_valid, sv);
      chk("m_last", m_last, e_last);
      chk("nw", nw, e_nw);
      chk("s0_ready", s0_ready, (md_ph == 1 && md_own == 0) ? m_ready : 1'b0);
      chk("s1_ready", s1_ready, (md_ph == 1 && md_own == 1) ? m_ready : 1'b0);
      chk("len", len, md_len);
      chk("k", k, md_k);
      chk("len_err", len_err, md_err);
      if (sv) chk("m_data", m_data, sd);
`ifdef FOLD_SCHED_FRMCNT_EN
      chk("frm_cnt0", frm_cnt0, mc0 & 16'hffff);
      chk("frm_cnt1", frm_cnt1, mc1 & 16'hffff);
`else
      chk("frm_cnt", {frm_cnt1, frm_cnt0}, 0);
`endif
      // advance to what the next edge must produce
      case (md_ph)
        0: begin
          md_err = 0;
          if (s0_valid || s1_valid) begin
            if (s0_valid && s1_valid) win = (md_lastsrv == 1) ? 0 : 1;
            else                      win = s1_valid ? 1 : 0;
            cl = (win == 1) ? int'(cfg1_len) : int'(cfg0_len);
            ck = (win == 1) ? int'(cfg1_k)   : int'(cfg0_k);
            if (cl == 0) cl = 1;
            if (ck > cl) ck = cl;
            md_own = win; md_lastsrv = win; md_len = cl; md_k = ck;
            md_beat = 1; md_ph = 1;
          end
        end
        1: begin
          md_err = 0;
          if (sv && m_ready) begin
            if (e_last != 0) begin
              md_err = ((md_beat == md_len) != sl) ? 1 : 0;
              if (md_own == 0) mc0++; else mc1++;
              md_ph = 2;
            end else md_beat++;
          end
        end
        default: begin md_ph = 0; md_err = 0; end
      endcase
    end
  end

  // Logs for literal per-scenario expectations.
  logic [31:0] nw_bits, last_bits;
  int nacc, err_cnt, busy_cyc;
  int grant_log[$], k_log[$], len_log[$];
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    if (resetn) begin
      if (m_valid && m_ready) begin
        nw_bits[nacc]   = nw;
        last_bits[nacc] = m_last;
        nacc++;
      end
      if (busy && !busy_q) begin
        grant_log.push_back(int'(grant));
        k_log.push_back(int'(k));
        len_log.push_back(int'(len));
      end
      if (len_err) err_cnt++;
      if (busy) busy_cyc++;
    end
    busy_q = resetn && busy;
  end

  task automatic clear_logs();
    nw_bits = '0; last_bits = '0; nacc = 0; err_cnt = 0; busy_cyc = 0;
    grant_log.delete(); k_log.delete(); len_log.delete();
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic run_idle(input string name);
    int n = 0;
    do begin cyc(); n++; end
    while ((q0.size() > 0 || q1.size() > 0 || busy) && n < 300);
    chk({name, "_done"}, (n < 300) ? 1 : 0, 1);
    cyc();
  endtask

  initial begin
    m_ready = 1'b1;
    cfg0_len = '0; cfg0_k = '0; cfg1_len = '0; cfg1_k = '0;
    drive();
    clear_logs();
    repeat (3) cyc();
    chk("init_busy", busy, 0);
    chk("init_grant", grant, 0);
    resetn = 1'b1;
    cyc();

    // single frame, nw on beats 6..8, one GAP cycle
    cfg0_len = 5'd8; cfg0_k = 5'd3;
    clear_logs();
    push(0, 8, 8'h10, -1); drive();
    run_idle("t1");
    chk("t1_beats", nacc, 8);
    chk("t1_nw", nw_bits[7:0], 8'hE0);
    chk("t1_last", last_bits[7:0], 8'h80);
    chk("t1_busy_cyc", busy_cyc, 9);

    // round robin from reset
    resetn = 1'b0; cyc(); resetn = 1'b1;
    cfg0_len = 5'd4; cfg0_k = 5'd0; cfg1_len = 5'd4; cfg1_k = 5'd0;
    clear_logs();
    push(0, 4, 8'h20, 4); push(0, 4, 8'h30, 4); push(1, 4, 8'h40, 4); drive();
    run_idle("t2");
    chk("t2_frames", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("t2_g0", grant_log[0], 1);
      chk("t2_g1", grant_log[1], 2);
      chk("t2_g2", grant_log[2], 1);
    end

    // early s_last on source 1
    cfg1_len = 5'd5; cfg1_k = 5'd2;
    clear_logs();
    push(1, 3, 8'h50, 3); drive();
    run_idle("t3");
    chk("t3_last", last_bits[2:0], 3'b100);
    chk("t3_err", err_cnt, 1);

    // missing s_last at len: frame cut, remainder is a new frame
    cfg0_len = 5'd4; cfg0_k = 5'd0;
    clear_logs();
    push(0, 6, 8'h60, 6); drive();
    run_idle("t4");
    chk("t4_last", last_bits[5:0], 6'b101000);
    chk("t4_frames", grant_log.size(), 2);
    chk("t4_err", err_cnt, 2);

    // k clamped to len
    cfg0_len = 5'd6; cfg0_k = 5'd9;
    clear_logs();
    push(0, 6, 8'h70, 6); drive();
    run_idle("t5a");
    if (k_log.size() > 0) chk("t5a_k", k_log[0], 6);
    chk("t5a_nw", nw_bits[5:0], 6'h3F);

    // len=0 -> 1-beat frames
    cfg0_len = 5'd0; cfg0_k = 5'd0;
    clear_logs();
    push(0, 3, 8'h80, 0); drive();
    run_idle("t5b");
    chk("t5b_frames", grant_log.size(), 3);
    chk("t5b_last", last_bits[2:0], 3'b111);
    if (len_log.size() > 0) chk("t5b_len", len_log[0], 1);

    // async reset mid-frame, pointer back to source 0
    cfg0_len = 5'd8; cfg0_k = 5'd3; cfg1_len = 5'd4; cfg1_k = 5'd0;
    clear_logs();
    push(0, 8, 8'h90, -1); drive();
    begin
      int n = 0;
      while (nacc < 2 && n < 50) begin cyc(); n++; end
      chk("t6_reach", (n < 50) ? 1 : 0, 1);
    end
    resetn = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_mvalid", m_valid, 0);
    chk("t6_grant", grant, 0);
    chk("t6_len", len, 0);
    q0.delete(); q1.delete(); drive();
    cyc(); cyc();
    clear_logs();
    push(0, 2, 8'hA0, 2); push(1, 2, 8'hB0, 2); drive();
    resetn = 1'b1;
    run_idle("t6");
    if (grant_log.size() > 0) chk("t6_first", grant_log[0], 1);
    chk("t6_frames", grant_log.size(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
